mem_stage_pipe: RTL and testbench
=================================

MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of data words and of the valA/valE operands.
REQ-002 SHALL have parameter DEPTH, default 1024: number of data-memory words.
REQ-003 SHALL have parameter LAT, default 2, legal range 1..4: memory-access latency in cycles.
REQ-004 SHALL have one clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-005 Ports, in order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  M-stage instruction present
- in_ready  out  1  stage can accept
- M_icode  in  4  instruction code
- M_valA  in  DATA_W  store data / ret-pop address
- M_valE  in  DATA_W  computed address / ALU result
- M_destE  in  4  E destination register
- M_destM  in  4  M destination register
- M_status  in  2  incoming status: 0 AOK, 1 ADR, 2 INS, 3 HLT
- out_valid  out  1  W-stage result valid, one-cycle pulse
- W_icode  out  4  registered icode
- W_valE  out  DATA_W  registered valE
- W_valM  out  DATA_W  loaded data
- W_destE  out  4  registered destE
- W_destM  out  4  registered destM
- W_status  out  2  final status
- halted  out  1  sticky stop flag

Function
REQ-006 SHALL accept an instruction on a rising clk edge where in_valid=1 and in_ready=1.
REQ-007 SHALL set in_ready = (state==IDLE) and not halted.
REQ-008 Write ops SHALL be: 0x4 rmmovq, 0x8 call, 0xA pushq; each writes mem[M_valE] <= M_valA.
REQ-009 Read ops SHALL be: 0x5 mrmovq, reading mem[M_valE]; 0x9 ret and 0xB popq, reading mem[M_valA].
REQ-010 Addresses SHALL be treated as unsigned DATA_W values; an address >= DEPTH is invalid.
REQ-011 An invalid address on a read or write op SHALL yield status ADR (1), with no write and W_valM = 0.
REQ-012 If M_status != 0 at accept, the stage SHALL perform no memory access, pass M_status through, and set W_valM = 0.
REQ-013 Writes SHALL commit at the accept edge, so the next accepted read sees the new data.
REQ-014 Read data SHALL be sampled at the accept edge and held until output.
REQ-015 FSM states SHALL be IDLE and WAIT.
- Read/write op accepted with LAT>1: IDLE -> WAIT, counter loaded with LAT-1.
- WAIT decrements each cycle; at zero -> IDLE and out_valid=1 that cycle.
- Non-memory op, or LAT=1: stay in IDLE; out_valid=1 on the cycle after accept.
REQ-016 Latency SHALL be: memory op, out_valid exactly LAT cycles after the accept edge; other ops, exactly 1 cycle after.
REQ-017 W_* outputs SHALL update only when out_valid rises and SHALL hold their value otherwise.
REQ-018 halted SHALL set in the cycle out_valid=1 with W_status != 0; it stays set until reset.
REQ-019 Any unrecognised icode SHALL pass through with W_valM = 0 and no memory access; status is not changed by the block.
REQ-020 No downstream backpressure SHALL exist; out_valid is a single-cycle pulse per instruction.

Reset
REQ-021 On rst_n=0 all outputs SHALL go to 0 immediately: out_valid, halted, all W_*, FSM state IDLE, counter 0.
REQ-022 Reset during WAIT SHALL drop the in-flight result (no out_valid); any write already committed remains.
REQ-023 Memory contents SHALL NOT be reset.
REQ-024 in_ready SHALL be 1 on the first edge after rst_n deasserts.

Verification (DEPTH=1024, LAT=2)
REQ-025 rmmovq valE=16 valA=0x1234, then mrmovq valE=16 -> second result: out_valid 2 cycles after its accept, W_valM=0x1234; in_ready low 1 cycle after each accept.
REQ-026 pushq valE=1023 valA=5, then popq valA=1023 -> W_valM=5, W_status=0.
REQ-027 mrmovq valE=1024 -> W_status=1, W_valM=0, halted=1; in_ready stays 0 for 10 further cycles.
REQ-028 opq icode 6, valE=7, destE=3 -> out_valid next cycle, W_valE=7, W_destE=3, in_ready never drops.
REQ-029 mrmovq accepted, then rst_n low during WAIT -> no out_valid pulse; all outputs 0; in_ready=1 after release.
REQ-030 rmmovq valE=8 valA=1, then rmmovq valE=8 valA=2 with M_status=3 -> W_status=3, halted=1; backdoor mem[8]==1.

Source files
------------

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: Y86-style memory stage with fixed-latency data memory, IDLE/WAIT FSM and sticky halt.
module mem_stage_pipe #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        M_icode,
    input  logic [DATA_W-1:0] M_valA,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        M_destE,
    input  logic [3:0]        M_destM,
    input  logic [1:0]        M_status,
    output logic              out_valid,
    output logic [3:0]        W_icode,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [3:0]        W_destE,
    output logic [3:0]        W_destM,
    output logic [1:0]        W_status,
    output logic              halted
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic [3:0]        icode;
        logic [DATA_W-1:0] val_e;
        logic [DATA_W-1:0] val_m;
        logic [3:0]        dest_e;
        logic [3:0]        dest_m;
        logic [1:0]        status;
    } res_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              halted_q, halted_d;
    res_t              w_q, w_d, p_q, p_d, res;
    logic              accept, is_wr, is_rd, adr_ok, we;
    logic [DATA_W-1:0] addr;

    assign in_ready  = (state_q == IDLE) && !halted_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign W_icode   = w_q.icode;
    assign W_valE    = w_q.val_e;
    assign W_valM    = w_q.val_m;
    assign W_destE   = w_q.dest_e;
    assign W_destM   = w_q.dest_m;
    assign W_status  = w_q.status;

    // ret/popq address the stack through valA; every other memory op uses valE
    always_comb begin
        accept     = in_valid && in_ready;
        is_wr      = (M_icode == 4'h4) || (M_icode == 4'h8) || (M_icode == 4'hA);
        is_rd      = (M_icode == 4'h5) || (M_icode == 4'h9) || (M_icode == 4'hB);
        addr       = ((M_icode == 4'h9) || (M_icode == 4'hB)) ? M_valA : M_valE;
        adr_ok     = addr < DATA_W'(DEPTH);
        we         = accept && is_wr && adr_ok && (M_status == 2'd0);
        res.icode  = M_icode;
        res.val_e  = M_valE;
        res.dest_e = M_destE;
        res.dest_m = M_destM;
        res.status = (M_status != 2'd0) ? M_status : ((is_wr || is_rd) && !adr_ok) ? 2'd1 : 2'd0;
        res.val_m  = ((M_status == 2'd0) && is_rd && adr_ok) ? mem[addr[AW-1:0]] : '0;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        w_d         = w_q;
        out_valid_d = 1'b0;
        halted_d    = halted_q;
        if (state_q == WAIT) begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                w_d         = p_q;
            end
        end else if (accept) begin
            if ((is_wr || is_rd) && (LAT > 1)) begin
                state_d = WAIT;
                cnt_d   = 2'(LAT - 1);
                p_d     = res;
            end else begin
                out_valid_d = 1'b1;
                w_d         = res;
            end
        end
        if (out_valid_d && (w_d.status != 2'd0)) halted_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            w_q         <= '0;
            p_q         <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            w_q         <= w_d;
            p_q         <= p_d;
        end
    end

    // data memory is deliberately outside reset so committed writes survive it
    always_ff @(posedge clk) begin
        if (we) mem[addr[AW-1:0]] <= M_valA;
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: scenario tasks with a reference-model scoreboard for mem_stage_pipe (DEPTH=1024, LAT=2).
module tb_mem_stage_pipe;
    localparam int DW = 64;

    logic          clk = 0, rst_n = 1, in_valid = 0;
    logic          in_ready, out_valid, halted;
    logic [3:0]    M_icode = 0, M_destE = 0, M_destM = 0;
    logic [DW-1:0] M_valA = 0, M_valE = 0;
    logic [1:0]    M_status = 0;
    logic [3:0]    W_icode, W_destE, W_destM;
    logic [DW-1:0] W_valE, W_valM;
    logic [1:0]    W_status;

    typedef struct {
        logic [3:0]    icode;
        logic [DW-1:0] val_e;
        logic [DW-1:0] val_m;
        logic [3:0]    dest_e;
        logic [3:0]    dest_m;
        logic [1:0]    status;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] mm[logic [DW-1:0]];
    int            total = 0, bad = 0;

    mem_stage_pipe #(.DATA_W(DW), .DEPTH(1024), .LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .M_icode(M_icode), .M_valA(M_valA), .M_valE(M_valE), .M_destE(M_destE),
        .M_destM(M_destM), .M_status(M_status), .out_valid(out_valid),
        .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM), .W_destE(W_destE),
        .W_destM(W_destM), .W_status(W_status), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        #2 rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    // independent reference model, evaluated when the instruction is driven
    task automatic send(input logic [3:0] ic, input logic [DW-1:0] va, input logic [DW-1:0] ve,
                        input logic [3:0] de, input logic [3:0] dm, input logic [1:0] st);
        exp_t          e;
        logic          wr, rd, ok;
        logic [DW-1:0] a;
        int            n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        a  = ((ic == 4'h9) || (ic == 4'hB)) ? va : ve;
        ok = a < 1024;
        e.icode  = ic;
        e.val_e  = ve;
        e.dest_e = de;
        e.dest_m = dm;
        e.status = (st != 0) ? st : ((wr || rd) && !ok) ? 2'd1 : 2'd0;
        e.val_m  = (st == 0 && rd && ok && mm.exists(a)) ? mm[a] : '0;
        if (st == 0 && wr && ok) mm[a] = va;
        sbq.push_back(e);
        M_icode = ic; M_valA = va; M_valE = ve; M_destE = de; M_destM = dm; M_status = st;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        #3;
        total++;
        if ({out_valid, halted, W_icode, W_valE, W_valM, W_destE, W_destM, W_status} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ov=%b h=%b st=%0d valM=%h, required all 0", out_valid, halted, W_status, W_valM);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_store_load();
        exp_t e;
        int   lat;
        send(4'h4, 64'h1234, 64'd16, 4'hF, 4'hF, 2'd0);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL st_ready_low: got %b required 0", in_ready); end
        wait_out(lat);
        e = sbq.pop_front();
        total++;
        if (lat != 2) begin bad++; $display("FAIL st_latency: got %0d required 2", lat); end
        total++;
        if ({W_icode, W_valE, W_valM, W_destE, W_destM, W_status} !== {e.icode, e.val_e, e.val_m, e.dest_e, e.dest_m, e.status}) begin
            bad++; $display("FAIL st_result: got ic=%h valM=%h st=%0d required ic=%h valM=%h st=%0d", W_icode, W_valM, W_status, e.icode, e.val_m, e.status);
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL st_ready_back: got %b required 1", in_ready); end
        send(4'h5, 64'd0, 64'd16, 4'hF, 4'h2, 2'd0);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL ld_ready_low: got %b required 0", in_ready); end
        wait_out(lat);
        e = sbq.pop_front();
        total++;
        if (lat != 2) begin bad++; $display("FAIL ld_latency: got %0d required 2", lat); end
        total++;
        if ({W_icode, W_valE, W_valM, W_destE, W_destM, W_status} !== {e.icode, e.val_e, e.val_m, e.dest_e, e.dest_m, e.status} || W_valM !== 64'h1234) begin
            bad++; $display("FAIL ld_result: got valM=%h st=%0d required valM=%h st=%0d", W_valM, W_status, e.val_m, e.status);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL ld_pulse: got out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_push_pop();
        exp_t e;
        int   lat;
        send(4'hA, 64'd5, 64'd1023, 4'h4, 4'hF, 2'd0);
        wait_out(lat);
        e = sbq.pop_front();
        send(4'hB, 64'd1023, 64'd1023, 4'h4, 4'h6, 2'd0);
        wait_out(lat);
        e = sbq.pop_front();
        total++;
        if (lat != 2) begin bad++; $display("FAIL pop_latency: got %0d required 2", lat); end
        total++;
        if ({W_icode, W_valE, W_valM, W_destE, W_destM, W_status} !== {e.icode, e.val_e, e.val_m, e.dest_e, e.dest_m, e.status} || W_valM !== 64'd5) begin
            bad++; $display("FAIL pop_result: got valM=%h st=%0d required valM=%h st=%0d", W_valM, W_status, e.val_m, e.status);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        send(4'h6, 64'd0, 64'd7, 4'h3, 4'hF, 2'd0);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL opq_ready: got %b required 1", in_ready); end
        wait_out(lat);
        e = sbq.pop_front();
        total++;
        if (lat != 1) begin bad++; $display("FAIL opq_latency: got %0d required 1", lat); end
        total++;
        if ({W_icode, W_valE, W_valM, W_destE, W_destM, W_status} !== {e.icode, e.val_e, e.val_m, e.dest_e, e.dest_m, e.status} || W_valE !== 64'd7 || W_destE !== 4'd3) begin
            bad++; $display("FAIL opq_result: got valE=%h destE=%h required valE=%h destE=%h", W_valE, W_destE, e.val_e, e.dest_e);
        end
        send(4'hC, 64'hAA, 64'd16, 4'h1, 4'h2, 2'd0);
        wait_out(lat);
        e = sbq.pop_front();
        total++;
        if (lat != 1) begin bad++; $display("FAIL unk_latency: got %0d required 1", lat); end
        total++;
        if ({W_icode, W_valE, W_valM, W_destE, W_destM, W_status} !== {e.icode, e.val_e, e.val_m, e.dest_e, e.dest_m, e.status}) begin
            bad++; $display("FAIL unk_result: got ic=%h valM=%h st=%0d required ic=%h valM=%h st=%0d", W_icode, W_valM, W_status, e.icode, e.val_m, e.status);
        end
    endtask

    task automatic test_reset_wait();
        int seen = 0;
        send(4'h5, 64'd0, 64'd16, 4'hF, 4'h1, 2'd0);
        #1 rst_n = 0;
        #1;
        total++;
        if ({out_valid, halted, W_icode, W_valE, W_valM, W_destE, W_destM, W_status} !== '0) begin
            bad++; $display("FAIL rw_outputs: got ov=%b valE=%h valM=%h required all 0", out_valid, W_valE, W_valM);
        end
        sbq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rw_ready: got %b required 1", in_ready); end
        repeat (4) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL rw_dropped: got %0d pulses required 0", seen); end
    endtask

    task automatic test_adr();
        exp_t e;
        int   lat, rdy = 0;
        send(4'h5, 64'd0, 64'd1024, 4'hF, 4'h1, 2'd0);
        wait_out(lat);
        e = sbq.pop_front();
        total++;
        if ({W_icode, W_valE, W_valM, W_destE, W_destM, W_status} !== {e.icode, e.val_e, e.val_m, e.dest_e, e.dest_m, e.status} || W_status !== 2'd1) begin
            bad++; $display("FAIL adr_result: got valM=%h st=%0d required valM=%h st=%0d", W_valM, W_status, e.val_m, e.status);
        end
        total++;
        if (halted !== 1'b1) begin bad++; $display("FAIL adr_halted: got %b required 1", halted); end
        repeat (10) begin
            @(posedge clk);
            #1;
            if (in_ready) rdy++;
        end
        total++;
        if (rdy != 0) begin bad++; $display("FAIL adr_ready_held: got %0d ready cycles required 0", rdy); end
        do_reset();
    endtask

    task automatic test_halt_status();
        exp_t e;
        int   lat;
        send(4'h4, 64'd1, 64'd8, 4'hF, 4'hF, 2'd0);
        wait_out(lat);
        e = sbq.pop_front();
        send(4'h4, 64'd2, 64'd8, 4'hF, 4'hF, 2'd3);
        wait_out(lat);
        e = sbq.pop_front();
        total++;
        if ({W_icode, W_valE, W_valM, W_destE, W_destM, W_status} !== {e.icode, e.val_e, e.val_m, e.dest_e, e.dest_m, e.status} || W_status !== 2'd3) begin
            bad++; $display("FAIL hlt_result: got st=%0d valM=%h required st=%0d valM=%h", W_status, W_valM, e.status, e.val_m);
        end
        total++;
        if (halted !== 1'b1) begin bad++; $display("FAIL hlt_halted: got %b required 1", halted); end
        total++;
        if (dut.mem[8] !== mm[64'd8]) begin bad++; $display("FAIL hlt_mem8: got %h required %h", dut.mem[8], mm[64'd8]); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_push_pop();
        test_back_to_back();
        test_reset_wait();
        test_adr();
        test_halt_status();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
